// File: rtl/id_ex_reg.sv
// Purpose : ID/EX pipeline register with load-use hazard detection and forwarding-select generation.
// Latency : 1 cycle ID -> EXE; Stall is combinational from ID inputs and current EXE state.
// Backpr. : on a load-use hazard Stall holds PC and IF/ID while a bubble enters EXE; Flush overrides.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ID_*                       decoded instruction from the ID stage
//   Flush                      wrong-path kill; forces a bubble and suppresses Stall
//   MEM_WriteReg, MEM_RegWrite destination of the instruction currently in MEM
//   EXE_*                      registered EXE-stage copy of the instruction
//   EXE_AluAsrc, EXE_AluBsrc   registered operand selects (A: 0 rf, 1 EXE, 2 MEM;
//                              B: 0 rf, 1 imm, 2 EXE, 3 MEM)
//   Stall                      hold PC and IF/ID this cycle
//   StallCnt                   saturating count of load-use bubbles
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_Valid,
    input  logic [31:0] ID_PC,
    input  logic [31:0] ID_RegA,
    input  logic [31:0] ID_RegB,
    input  logic [31:0] ID_Imm32,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_WriteReg,
    input  logic        ID_UseRt,
    input  logic        ID_AluBImm,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic [3:0]  ID_ALUOp,
    input  logic        Flush,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        MEM_RegWrite,
    output logic        EXE_Valid,
    output logic [31:0] EXE_PC,
    output logic [31:0] EXE_RegA,
    output logic [31:0] EXE_RegB,
    output logic [31:0] EXE_Imm32,
    output logic [4:0]  EXE_WriteReg,
    output logic        EXE_RegWrite,
    output logic        EXE_MemRead,
    output logic        EXE_MemWrite,
    output logic [3:0]  EXE_ALUOp,
    output logic [1:0]  EXE_AluAsrc,
    output logic [1:0]  EXE_AluBsrc,
    output logic        Stall,
    output logic [15:0] StallCnt
);

    logic       hazard;
    logic       exeHitA;
    logic       exeHitB;
    logic       memHitA;
    logic       memHitB;
    logic [1:0] aSrcNext;
    logic [1:0] bSrcNext;
    logic [15:0] stallCntQ;

    // A load in EXE whose result is needed by the instruction in ID cannot be
    // forwarded in time; the ID instruction must wait one cycle.
    always_comb begin
        hazard = ID_Valid && EXE_Valid && EXE_MemRead && (EXE_WriteReg != 5'd0) &&
                 ((EXE_WriteReg == ID_Rs) || (ID_UseRt && (EXE_WriteReg == ID_Rt)));
    end

    assign Stall = hazard && !Flush;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    // The EXE-stage producer is younger than the MEM-stage one and wins.
    always_comb begin
        exeHitA = (ID_Rs != 5'd0) && EXE_Valid && EXE_RegWrite && (EXE_WriteReg == ID_Rs);
        exeHitB = (ID_Rt != 5'd0) && EXE_Valid && EXE_RegWrite && (EXE_WriteReg == ID_Rt);
        memHitA = (ID_Rs != 5'd0) && MEM_RegWrite && (MEM_WriteReg == ID_Rs);
        memHitB = (ID_Rt != 5'd0) && MEM_RegWrite && (MEM_WriteReg == ID_Rt);

        aSrcNext = 2'd0;
        if (exeHitA) begin
            aSrcNext = 2'd1;
        end else if (memHitA) begin
            aSrcNext = 2'd2;
        end

        bSrcNext = 2'd0;
        if (ID_AluBImm) begin
            bSrcNext = 2'd1;
        end else if (exeHitB) begin
            bSrcNext = 2'd2;
        end else if (memHitB) begin
            bSrcNext = 2'd3;
        end
    end

    // Pipeline register: Flush and hazard both insert an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EXE_Valid    <= 1'b0;
            EXE_PC       <= 32'd0;
            EXE_RegA     <= 32'd0;
            EXE_RegB     <= 32'd0;
            EXE_Imm32    <= 32'd0;
            EXE_WriteReg <= 5'd0;
            EXE_RegWrite <= 1'b0;
            EXE_MemRead  <= 1'b0;
            EXE_MemWrite <= 1'b0;
            EXE_ALUOp    <= 4'd0;
            EXE_AluAsrc  <= 2'd0;
            EXE_AluBsrc  <= 2'd0;
        end else if (Flush || hazard) begin
            EXE_Valid    <= 1'b0;
            EXE_PC       <= 32'd0;
            EXE_RegA     <= 32'd0;
            EXE_RegB     <= 32'd0;
            EXE_Imm32    <= 32'd0;
            EXE_WriteReg <= 5'd0;
            EXE_RegWrite <= 1'b0;
            EXE_MemRead  <= 1'b0;
            EXE_MemWrite <= 1'b0;
            EXE_ALUOp    <= 4'd0;
            EXE_AluAsrc  <= 2'd0;
            EXE_AluBsrc  <= 2'd0;
        end else begin
            EXE_Valid    <= ID_Valid;
            EXE_PC       <= ID_PC;
            EXE_RegA     <= ID_RegA;
            EXE_RegB     <= ID_RegB;
            EXE_Imm32    <= ID_Imm32;
            EXE_WriteReg <= ID_WriteReg;
            EXE_RegWrite <= ID_RegWrite;
            EXE_MemRead  <= ID_MemRead;
            EXE_MemWrite <= ID_MemWrite;
            EXE_ALUOp    <= ID_ALUOp;
            EXE_AluAsrc  <= aSrcNext;
            EXE_AluBsrc  <= bSrcNext;
        end
    end

    // Only bubbles that actually stall the front end are counted; a flushed
    // hazard costs nothing extra because the ID instruction is dead anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= 16'd0;
        end else if (Stall && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign StallCnt = stallCntQ;

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ID_Valid;
    logic [31:0] ID_PC, ID_RegA, ID_RegB, ID_Imm32;
    logic [4:0]  ID_Rs, ID_Rt, ID_WriteReg;
    logic        ID_UseRt, ID_AluBImm, ID_RegWrite, ID_MemRead, ID_MemWrite;
    logic [3:0]  ID_ALUOp;
    logic        Flush;
    logic [4:0]  MEM_WriteReg;
    logic        MEM_RegWrite;
    logic        EXE_Valid;
    logic [31:0] EXE_PC, EXE_RegA, EXE_RegB, EXE_Imm32;
    logic [4:0]  EXE_WriteReg;
    logic        EXE_RegWrite, EXE_MemRead, EXE_MemWrite;
    logic [3:0]  EXE_ALUOp;
    logic [1:0]  EXE_AluAsrc, EXE_AluBsrc;
    logic        Stall;
    logic [15:0] StallCnt;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_RegA(ID_RegA), .ID_RegB(ID_RegB),
        .ID_Imm32(ID_Imm32), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WriteReg(ID_WriteReg),
        .ID_UseRt(ID_UseRt), .ID_AluBImm(ID_AluBImm), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_ALUOp(ID_ALUOp),
        .Flush(Flush), .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite),
        .EXE_Valid(EXE_Valid), .EXE_PC(EXE_PC), .EXE_RegA(EXE_RegA), .EXE_RegB(EXE_RegB),
        .EXE_Imm32(EXE_Imm32), .EXE_WriteReg(EXE_WriteReg), .EXE_RegWrite(EXE_RegWrite),
        .EXE_MemRead(EXE_MemRead), .EXE_MemWrite(EXE_MemWrite), .EXE_ALUOp(EXE_ALUOp),
        .EXE_AluAsrc(EXE_AluAsrc), .EXE_AluBsrc(EXE_AluBsrc),
        .Stall(Stall), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction the bench believes sits in EXE.
    typedef struct {
        logic        valid;
        logic [31:0] pc, regA, regB, imm;
        logic [4:0]  writeReg;
        logic        regWrite, memRead, memWrite;
        logic [3:0]  aluOp;
        logic [1:0]  aSrc, bSrc;
    } exeState_t;

    exeState_t m;
    int        cnt;
    int        passCnt = 0;
    int        totalCnt = 0;

    function automatic exeState_t bubble();
        exeState_t b;
        b.valid = 0; b.pc = 0; b.regA = 0; b.regB = 0; b.imm = 0; b.writeReg = 0;
        b.regWrite = 0; b.memRead = 0; b.memWrite = 0; b.aluOp = 0; b.aSrc = 0; b.bSrc = 0;
        return b;
    endfunction

    // Search in-flight writers youngest first; returns 1 for EXE, 2 for MEM, 0 for none.
    function automatic int producerStage(input logic [4:0] r);
        logic [4:0] dst [2];
        bit         wr  [2];
        dst[0] = m.writeReg;   wr[0] = m.valid && m.regWrite;
        dst[1] = MEM_WriteReg; wr[1] = MEM_RegWrite;
        if (r == 5'd0) return 0;
        for (int i = 0; i < 2; i++)
            if (wr[i] && dst[i] == r) return i + 1;
        return 0;
    endfunction

    function automatic bit modelHazard();
        if (!(ID_Valid && m.valid && m.memRead && m.writeReg != 0)) return 0;
        return (ID_Rs == m.writeReg) || (ID_UseRt && ID_Rt == m.writeReg);
    endfunction

    function automatic exeState_t modelNext(input bit hz);
        exeState_t n;
        int p;
        if (Flush || hz) return bubble();
        n.valid = ID_Valid; n.pc = ID_PC; n.regA = ID_RegA; n.regB = ID_RegB;
        n.imm = ID_Imm32; n.writeReg = ID_WriteReg; n.regWrite = ID_RegWrite;
        n.memRead = ID_MemRead; n.memWrite = ID_MemWrite; n.aluOp = ID_ALUOp;
        n.aSrc = 2'(producerStage(ID_Rs));
        p = producerStage(ID_Rt);
        n.bSrc = ID_AluBImm ? 2'd1 : (p == 0 ? 2'd0 : 2'(p + 1));
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".Valid"},    32'(EXE_Valid),    32'(m.valid));
        chk({tag, ".PC"},       EXE_PC,            m.pc);
        chk({tag, ".RegA"},     EXE_RegA,          m.regA);
        chk({tag, ".RegB"},     EXE_RegB,          m.regB);
        chk({tag, ".Imm"},      EXE_Imm32,         m.imm);
        chk({tag, ".WriteReg"}, 32'(EXE_WriteReg), 32'(m.writeReg));
        chk({tag, ".RegWrite"}, 32'(EXE_RegWrite), 32'(m.regWrite));
        chk({tag, ".MemRead"},  32'(EXE_MemRead),  32'(m.memRead));
        chk({tag, ".MemWrite"}, 32'(EXE_MemWrite), 32'(m.memWrite));
        chk({tag, ".ALUOp"},    32'(EXE_ALUOp),    32'(m.aluOp));
        chk({tag, ".Asrc"},     32'(EXE_AluAsrc),  32'(m.aSrc));
        chk({tag, ".Bsrc"},     32'(EXE_AluBsrc),  32'(m.bSrc));
        chk({tag, ".StallCnt"}, 32'(StallCnt),     32'(cnt));
    endtask

    task automatic setId(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input bit useRt, input bit bImm,
                         input bit rw, input bit mr, input bit mw);
        ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_WriteReg = wr; ID_UseRt = useRt;
        ID_AluBImm = bImm; ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw;
        ID_PC = $urandom; ID_RegA = $urandom; ID_RegB = $urandom; ID_Imm32 = $urandom;
        ID_ALUOp = 4'($urandom_range(0, 15));
    endtask

    task automatic setMem(input logic [4:0] wr, input bit rw);
        MEM_WriteReg = wr; MEM_RegWrite = rw;
    endtask

    // Called at a negedge with inputs already driven: checks Stall, clocks once,
    // then checks the registered state at the following negedge.
    task automatic cycle(input string tag);
        bit hz;
        #1;
        hz = modelHazard();
        chk({tag, ".Stall"}, 32'(Stall), 32'(hz && !Flush));
        @(posedge clk);
        m = modelNext(hz);
        if (hz && !Flush && cnt < 65535) cnt++;
        @(negedge clk);
        checkAll(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        Flush = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 0);
        setMem(0, 0);
        m = bubble();
        cnt = 0;

        // Reset state
        repeat (2) @(negedge clk);
        checkAll("reset");
        chk("reset.Stall", 32'(Stall), 32'd0);
        rst_n = 1'b1;

        // Back-to-back: add r3 then consumer of r3
        setId(1, 1, 2, 3, 1, 0, 1, 0, 0);
        cycle("add_r3");
        setId(1, 3, 2, 9, 1, 0, 1, 0, 0);
        cycle("use_r3");
        chk("b2b.Asrc", 32'(EXE_AluAsrc), 32'd1);

        // Two-ahead: r5 written by MEM, EXE writes r9 (not r5)
        setMem(5, 1);
        setId(1, 5, 5, 10, 1, 0, 1, 0, 0);
        cycle("two_ahead");
        chk("two_ahead.Asrc", 32'(EXE_AluAsrc), 32'd2);
        chk("two_ahead.Bsrc", 32'(EXE_AluBsrc), 32'd3);
        setMem(0, 0);

        // Load-use: lw r4, then consumer of r4
        setId(1, 1, 2, 4, 0, 1, 1, 1, 0);
        cycle("lw_r4");
        setId(1, 4, 2, 11, 1, 0, 1, 0, 0);
        cycle("load_use");
        chk("load_use.Valid", 32'(EXE_Valid), 32'd0);
        chk("load_use.Cnt", 32'(StallCnt), 32'd1);
        setMem(4, 1);                   // the load now sits in MEM
        cycle("retry");
        chk("retry.Asrc", 32'(EXE_AluAsrc), 32'd2);
        setMem(0, 0);

        // Immediate beats an EXE match on Rt
        setId(1, 1, 2, 6, 0, 0, 1, 0, 0);
        cycle("add_r6");
        setId(1, 1, 6, 12, 0, 1, 1, 0, 0);
        cycle("imm");
        chk("imm.Bsrc", 32'(EXE_AluBsrc), 32'd1);

        // Writer to r0 (passed through) is never forwarded
        setId(1, 1, 2, 0, 1, 0, 1, 0, 0);
        cycle("wr_r0");
        chk("wr_r0.WriteRegPass", 32'(EXE_RegWrite), 32'd1);
        setMem(0, 1);
        setId(1, 0, 0, 13, 1, 0, 1, 0, 0);
        cycle("use_r0");
        chk("r0.Asrc", 32'(EXE_AluAsrc), 32'd0);
        chk("r0.Bsrc", 32'(EXE_AluBsrc), 32'd0);
        setMem(0, 0);

        // Flush with simultaneous hazard
        setId(1, 1, 2, 7, 1, 0, 1, 1, 0);
        cycle("lw_r7");
        setId(1, 7, 2, 14, 1, 0, 1, 0, 0);
        Flush = 1'b1;
        cycle("flush_hz");
        chk("flush_hz.Valid", 32'(EXE_Valid), 32'd0);
        chk("flush_hz.Cnt", 32'(StallCnt), 32'd1);
        Flush = 1'b0;

        // Async reset mid-stall
        setId(1, 1, 2, 8, 1, 0, 1, 1, 0);
        cycle("lw_r8");
        setId(1, 8, 2, 15, 1, 0, 1, 0, 0);
        #1;
        chk("pre_rst.Stall", 32'(Stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m = bubble();
        cnt = 0;
        checkAll("async_rst");
        chk("async_rst.Stall", 32'(Stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst");
        chk("post_rst.Valid", 32'(EXE_Valid), 32'd1);

        // Saturation: preset the counter, then hazards must leave it at FFFF
        force dut.stallCntQ = 16'hFFFF;
        #1;
        release dut.stallCntQ;
        cnt = 65535;
        for (int k = 0; k < 2; k++) begin
            setId(1, 1, 2, 16, 1, 0, 1, 1, 0);
            cycle("sat_lw");
            setId(1, 16, 2, 17, 1, 0, 1, 0, 0);
            cycle("sat_hz");
            chk("sat.Cnt", 32'(StallCnt), 32'hFFFF);
        end

        // Randomized traffic over a small register set to provoke collisions
        for (int k = 0; k < 300; k++) begin
            setId($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            setMem(5'($urandom_range(0, 7)), $urandom_range(0, 1));
            Flush = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
